// File: rtl/inbuf_pkg.sv
// Shared types and width helpers for the multi-bank input buffer.
// Holds the stream FSM state enum and the beat/pointer width functions.
package inbuf_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_e;

    // Width of a counter that must hold values 0..n-1 (never narrower than 1).
    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int beat_w(input int hidden, input int chunk);
        return clog2_min1(hidden / chunk);
    endfunction

    function automatic int ptr_w(input int banks);
        return clog2_min1(banks);
    endfunction

endpackage

// File: rtl/inbuf_bank_ring.sv
// Ring of vector banks with circular write and read pointers.
// The bank at the read pointer is presented combinationally on rd_data.
module inbuf_bank_ring
    import inbuf_pkg::*;
#(
    parameter int HIDDEN_SIZE = 768,
    parameter int BITWIDTH    = 4,
    parameter int NUM_BANKS   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_en,
    input  logic [HIDDEN_SIZE*BITWIDTH-1:0] wr_data,
    input  logic                          rd_adv,
    output logic [HIDDEN_SIZE*BITWIDTH-1:0] rd_data
);

    localparam int VW = HIDDEN_SIZE * BITWIDTH;
    localparam int PW = ptr_w(NUM_BANKS);
    localparam logic [PW-1:0] PTR_LAST = PW'(NUM_BANKS - 1);

    logic [VW-1:0] bank_q [NUM_BANKS];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;

    // Advance each pointer modulo NUM_BANKS on its event.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_en) begin
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PW'(1);
        end
        if (rd_adv) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PW'(1);
        end
    end

    // Pointer registers; reset discards every stored vector.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Bank storage needs no reset: occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            bank_q[wr_ptr_q] <= wr_data;
        end
    end

    assign rd_data = bank_q[rd_ptr_q];

endmodule

// File: rtl/input_buffer_nbank.sv
// N-bank input vector buffer streaming the oldest vector in CHUNK beats.
// Define INBUF_REPLAY_EN to add the keep port for re-streaming a vector.
module input_buffer_nbank
    import inbuf_pkg::*;
#(
    parameter int HIDDEN_SIZE = 768,
    parameter int BITWIDTH    = 4,
    parameter int NUM_BANKS   = 4,
    parameter int CHUNK       = 32
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [HIDDEN_SIZE*BITWIDTH-1:0]   in_data,
    input  logic                              proj_req,
`ifdef INBUF_REPLAY_EN
    input  logic                              keep,
`endif
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [CHUNK*BITWIDTH-1:0]         out_data,
    output logic                              out_last,
    output logic [$clog2(NUM_BANKS+1)-1:0]    count
);

    localparam int VW     = HIDDEN_SIZE * BITWIDTH;
    localparam int OW     = CHUNK * BITWIDTH;
    localparam int NBEATS = HIDDEN_SIZE / CHUNK;
    localparam int BW     = beat_w(HIDDEN_SIZE, CHUNK);
    localparam int CW     = $clog2(NUM_BANKS + 1);
    localparam logic [BW-1:0] BEAT_LAST = BW'(NBEATS - 1);

    state_e        state_q, state_d;
    logic [BW-1:0] beat_q, beat_d;
    logic [CW-1:0] count_q, count_d;
    logic [VW-1:0] rd_data;
    logic          wr_fire;
    logic          proj_fire;
    logic          last_fire;
    logic          free_bank;
    logic          hold_bank;

    assign in_ready  = (count_q < CW'(NUM_BANKS));
    assign wr_fire   = in_valid && in_ready;
    assign out_valid = (state_q == STREAM);
    assign out_last  = out_valid && (beat_q == BEAT_LAST);
    assign proj_fire = (state_q == IDLE) && proj_req && (count_q != '0);
    assign last_fire = out_valid && out_ready && out_last;
    assign free_bank = last_fire && !hold_bank;
    assign count     = count_q;

`ifdef INBUF_REPLAY_EN
    logic keep_q, keep_d;

    // Latch keep with the accepted request; it governs that whole stream.
    always_comb begin
        keep_d = keep_q;
        if (proj_fire) begin
            keep_d = keep;
        end
    end

    // Keep flag register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            keep_q <= 1'b0;
        end else begin
            keep_q <= keep_d;
        end
    end

    assign hold_bank = keep_q;
`else
    assign hold_bank = 1'b0;
`endif

    inbuf_bank_ring #(
        .HIDDEN_SIZE (HIDDEN_SIZE),
        .BITWIDTH    (BITWIDTH),
        .NUM_BANKS   (NUM_BANKS)
    ) u_ring (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_fire),
        .wr_data (in_data),
        .rd_adv  (free_bank),
        .rd_data (rd_data)
    );

    // Stream FSM and beat counter: beat moves only on a handshake.
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        unique case (state_q)
            IDLE: begin
                beat_d = '0;
                if (proj_fire) begin
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (out_ready) begin
                    if (out_last) begin
                        state_d = IDLE;
                        beat_d  = '0;
                    end else begin
                        beat_d = beat_q + BW'(1);
                    end
                end
            end
        endcase
    end

    // Occupancy: a write and a free in one cycle cancel out.
    always_comb begin
        count_d = count_q;
        unique case ({wr_fire, free_bank})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // FSM, beat and occupancy registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            beat_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            count_q <= count_d;
        end
    end

    // Beat slice of the streamed bank; forced to zero outside a stream.
    always_comb begin
        out_data = '0;
        if (out_valid) begin
            out_data = rd_data[int'(beat_q) * OW +: OW];
        end
    end

endmodule

// File: tb/tb_input_buffer_nbank.sv
// Scoreboard bench for input_buffer_nbank with a queue-based reference.
// Define INBUF_REPLAY_EN to also exercise the keep/replay path.
module tb_input_buffer_nbank;

    localparam int HS     = 8;
    localparam int BWD    = 4;
    localparam int NB     = 2;
    localparam int CH     = 2;
    localparam int NBEATS = HS / CH;
    localparam int VW     = HS * BWD;
    localparam int OW     = CH * BWD;
    localparam int CW     = $clog2(NB + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [VW-1:0] in_data;
    logic          proj_req;
    logic          out_valid;
    logic          out_ready;
    logic [OW-1:0] out_data;
    logic          out_last;
    logic [CW-1:0] count;
`ifdef INBUF_REPLAY_EN
    logic          keep;
`endif

    input_buffer_nbank #(
        .HIDDEN_SIZE (HS),
        .BITWIDTH    (BWD),
        .NUM_BANKS   (NB),
        .CHUNK       (CH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .proj_req  (proj_req),
`ifdef INBUF_REPLAY_EN
        .keep      (keep),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .count     (count)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: stored vectors as a FIFO, plus the active stream position.
    logic [VW-1:0] m_fifo[$];
    logic [OW:0]   exp_q[$];
    logic [OW-1:0] seen_q[$];
    bit            m_stream = 0;
    int            m_beat = 0;
    bit            m_keep = 0;

    always @(posedge clk or posedge rst) begin
        int sz;
        bit was_stream;
        logic [VW-1:0] v;
        if (rst) begin
            m_fifo.delete();
            exp_q.delete();
            m_stream = 0;
            m_beat = 0;
            m_keep = 0;
        end else begin
            sz = m_fifo.size();
            was_stream = m_stream;
            if (m_stream && out_ready) begin
                if (m_beat == NBEATS - 1) begin
                    m_stream = 0;
                    m_beat = 0;
                    if (!m_keep) void'(m_fifo.pop_front());
                end else begin
                    m_beat++;
                end
            end
            if (in_valid && sz < NB) m_fifo.push_back(in_data);
            if (!was_stream && proj_req && sz != 0) begin
                m_stream = 1;
                m_beat = 0;
`ifdef INBUF_REPLAY_EN
                m_keep = keep;
`else
                m_keep = 0;
`endif
                v = m_fifo[0];
                for (int b = 0; b < NBEATS; b++) begin
                    exp_q.push_back({(b == NBEATS - 1) ? 1'b1 : 1'b0,
                                     OW'(v >> (b * OW))});
                end
            end
        end
    end

    // Monitor: compares DUT outputs against the reference each cycle.
    bit            mon_en = 0;
    bit            prev_stall = 0;
    logic [OW-1:0] prev_data;

    always @(negedge clk) begin
        logic [OW:0] e;
        if (rst || !mon_en) begin
            prev_stall = 0;
        end else begin
            check("out_valid", 64'(out_valid), 64'(m_stream));
            check("count", 64'(count), 64'(m_fifo.size()));
            check("in_ready", 64'(in_ready), 64'(m_fifo.size() < NB));
            if (prev_stall) check("hold", 64'(out_data), 64'(prev_data));
            if (out_valid && out_ready) begin
                seen_q.push_back(out_data);
                check("beat_expected", 64'(exp_q.size() > 0), 64'(1));
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("beat_data", 64'(out_data), 64'(e[OW-1:0]));
                    check("beat_last", 64'(out_last), 64'(e[OW]));
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data = out_data;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write(input logic [VW-1:0] v);
        in_valid = 1'b1;
        in_data = v;
        step();
        in_valid = 1'b0;
    endtask

    task automatic proj(input bit k);
        proj_req = 1'b1;
`ifdef INBUF_REPLAY_EN
        keep = k;
`endif
        step();
        proj_req = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 60; i++) begin
            if (!m_stream && exp_q.size() == 0) break;
            step();
        end
        check(name, 64'(exp_q.size() + int'(m_stream)), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [OW-1:0] ref34 [4];
        bit found;
        ref34 = '{8'h10, 8'h32, 8'h54, 8'h76};
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        proj_req = 1'b0;
        out_ready = 1'b1;
`ifdef INBUF_REPLAY_EN
        keep = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        check("rst_count", 64'(count), 64'(0));
        check("rst_in_ready", 64'(in_ready), 64'(1));
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_out_last", 64'(out_last), 64'(0));
        check("rst_out_data", 64'(out_data), 64'(0));
        #3 rst = 1'b0;
        mon_en = 1;
        step();

        // Single vector streamed with out_ready held high.
        seen_q.delete();
        write(32'h7654_3210);
        proj(0);
        drain("drain_basic");
        check("basic_nbeats", 64'(seen_q.size()), 64'(4));
        for (int i = 0; i < 4 && i < seen_q.size(); i++) begin
            check("basic_beat", 64'(seen_q[i]), 64'(ref34[i]));
        end

        // Full buffer rejects a third vector.
        write(32'hAAAA_0001);
        write(32'hBBBB_0002);
        write(32'hCCCC_0003);
        check("full_count", 64'(count), 64'(2));
        check("full_in_ready", 64'(in_ready), 64'(0));
        proj(0);
        drain("drain_full1");
        check("after_free_ready", 64'(in_ready), 64'(1));
        proj(0);
        drain("drain_full2");

        // Backpressure pattern during a stream.
        write(32'h1357_9BDF);
        proj(0);
        out_ready = 1'b1; step();
        out_ready = 1'b0; step();
        out_ready = 1'b0; step();
        out_ready = 1'b1; step();
        drain("drain_bp");

        // Write landing on the same edge as the last-beat free.
        write(32'hDEAD_BEEF);
        proj(0);
        found = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_last) begin
                found = 1;
                break;
            end
        end
        check("sim_last_seen", 64'(found), 64'(1));
        in_valid = 1'b1;
        in_data = 32'hCAFE_F00D;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("sim_count", 64'(count), 64'(1));
        proj(0);
        drain("drain_sim");

        // Asynchronous reset in the middle of a stream.
        write(32'h0F1E_2D3C);
        proj(0);
        found = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (m_stream && m_beat == 2) begin
                found = 1;
                break;
            end
        end
        check("abort_beat2_seen", 64'(found), 64'(1));
        #1 rst = 1'b1;
        #1;
        check("abort_out_valid", 64'(out_valid), 64'(0));
        check("abort_count", 64'(count), 64'(0));
        check("abort_in_ready", 64'(in_ready), 64'(1));
        @(posedge clk);
        #3 rst = 1'b0;
        step();

`ifdef INBUF_REPLAY_EN
        // Replay: the kept vector streams twice, then is freed.
        write(32'h8899_AABB);
        proj(1);
        drain("drain_keep1");
        check("keep1_count", 64'(count), 64'(1));
        proj(1);
        drain("drain_keep2");
        check("keep2_count", 64'(count), 64'(1));
        proj(0);
        drain("drain_keep3");
        check("keep3_count", 64'(count), 64'(0));
`endif

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_data = VW'($urandom);
            proj_req = ($urandom_range(0, 3) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
`ifdef INBUF_REPLAY_EN
            keep = 1'($urandom_range(0, 1));
`endif
            step();
        end
        in_valid = 1'b0;
        proj_req = 1'b0;
        out_ready = 1'b1;
        drain("drain_random");

        check("final_exp_empty", 64'(exp_q.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/input_buffer_nbank.md
INPUT_BUFFER_NBANK -- requirements
Module: input_buffer_nbank

Interface
REQ-001 SHALL have parameter HIDDEN_SIZE, default 768: number of elements per input vector.
REQ-002 SHALL have parameter BITWIDTH, default 4: bits per element.
REQ-003 SHALL have parameter NUM_BANKS, default 4: number of vector banks, >=2.
REQ-004 SHALL have parameter CHUNK, default 32: elements per output beat; HIDDEN_SIZE % CHUNK == 0.
REQ-005 SHALL have port clk, input, 1: single clock, rising edge.
REQ-006 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-007 SHALL have port in_valid, input, 1: write vector offered.
REQ-008 SHALL have port in_ready, output, 1: a free bank exists.
REQ-009 SHALL have port in_data, input, HIDDEN_SIZE*BITWIDTH: vector to store.
REQ-010 SHALL have port proj_req, input, 1: start streaming the oldest stored vector.
REQ-011 SHALL have port out_valid, output, 1: out_data beat valid.
REQ-012 SHALL have port out_ready, input, 1: consumer accepts beat.
REQ-013 SHALL have port out_data, output, CHUNK*BITWIDTH: current beat.
REQ-014 SHALL have port out_last, output, 1: current beat is final beat of vector.
REQ-015 SHALL have port count, output, $clog2(NUM_BANKS+1): number of occupied banks.

Function
REQ-016 SHALL store a vector into bank[wr_ptr] on a cycle with in_valid && in_ready; wr_ptr increments mod NUM_BANKS.
REQ-017 SHALL drive in_ready = (count < NUM_BANKS), from registered count only; a same-cycle free does not raise in_ready.
REQ-018 SHALL use FSM states IDLE and STREAM; IDLE->STREAM on proj_req && count!=0; STREAM->IDLE on handshake (out_valid && out_ready) of the last beat.
REQ-019 SHALL ignore proj_req while count==0 or in STREAM.
REQ-020 SHALL assert out_valid exactly while in STREAM; first beat appears the cycle after proj_req is accepted.
REQ-021 SHALL drive out_data = elements [beat*CHUNK .. beat*CHUNK+CHUNK-1] of bank[rd_ptr]; beat 0 = least-significant bits.
REQ-022 SHALL advance beat only on out_valid && out_ready and hold out_data stable otherwise.
REQ-023 SHALL assert out_last when beat == HIDDEN_SIZE/CHUNK-1.
REQ-024 SHALL, on last-beat handshake, free the bank: rd_ptr increments mod NUM_BANKS, beat resets to 0, count decrements.
REQ-025 SHALL keep count unchanged when a write and a free occur in the same cycle.
REQ-026 SHALL never overwrite the bank being streamed (guaranteed by REQ-017).
REQ-027 SHALL allow back-to-back vectors: proj_req in the cycle after STREAM->IDLE starts the next vector.

Reset
REQ-028 SHALL, on rst, force: state IDLE, wr_ptr=0, rd_ptr=0, beat=0, count=0, out_valid=0, out_last=0, out_data=0, in_ready=1.
REQ-029 SHALL abort an in-progress stream on rst mid-operation, discarding all stored vectors; bank contents need not be cleared.

Configuration
REQ-030 SHALL support macro INBUF_REPLAY_EN: when defined, add input port keep (1 bit), sampled with an accepted proj_req; if keep=1, the last-beat handshake returns to IDLE without freeing the bank (rd_ptr and count unchanged), so the same vector is re-streamed for a further projection.
REQ-031 SHALL, without INBUF_REPLAY_EN, have no keep port and always free the bank per REQ-024.

Structure
REQ-032 SHALL place the FSM state enum (IDLE, STREAM) and beat-count/pointer width helper functions in shared package inbuf_pkg.
REQ-033 SHALL implement bank storage plus write/read pointers as sub-module inbuf_bank_ring; the FSM, beat counter and slice mux reside in the top module.

Verification (HIDDEN_SIZE=8, BITWIDTH=4, CHUNK=2, NUM_BANKS=2: 4 beats of 8 bits)
REQ-034 SHALL check: write 0x76543210, proj_req, out_ready=1 -> beats 0x10,0x32,0x54,0x76 on consecutive cycles, out_last on 4th, count 1->0.
REQ-035 SHALL check: two writes -> in_ready=0, count=2; third in_valid is not accepted; after one full stream, in_ready=1.
REQ-036 SHALL check: out_ready toggled 1,0,0,1 during stream -> out_data held while low; no beat skipped or duplicated.
REQ-037 SHALL check: write and last-beat free in the same cycle -> count stays 1; next stream delivers the new vector.
REQ-038 SHALL check: rst asserted at beat 2 -> out_valid=0, count=0, in_ready=1 immediately (asynchronous).
REQ-039 SHALL check, with INBUF_REPLAY_EN: proj_req with keep=1 twice -> identical beat sequences both times, count=1; then keep=0 -> count=0.
